// File: rtl/eth_frame_gen_if.sv
// eth_frame_gen_if: request and serial-output signals of the 10BASE-T frame
// generator.
//   transmit   : start request, level-sampled
//   enable     : block enable, requests are ignored while low
//   eth_data_s : serial NRZ frame bit, one bit per clock
//   Tx         : high exactly while a frame bit is on eth_data_s
// master = requester (drives transmit/enable), slave = generator.
interface eth_frame_gen_if;
  logic transmit;
  logic enable;
  logic eth_data_s;
  logic Tx;

  modport master (output transmit, enable, input  eth_data_s, Tx);
  modport slave  (input  transmit, enable, output eth_data_s, Tx);
endinterface

// File: rtl/eth_frame_gen.sv
// eth_frame_gen: serial Ethernet frame generator, 10 MHz bit clock.
// On a request it emits preamble, SFD, header, a seeded payload and an
// optional FCS, each byte LSB first, then holds 96 bit times of IFG.
// Optional feature macro: ETH_FRAME_FCS_EN (adds the CRC-32 FCS state).
// Ports:
//   clk   : bit clock, rising edge
//   rst_n : asynchronous active-low reset, drops any frame in flight
//   bus   : eth_frame_gen_if.slave (transmit, enable in; eth_data_s, Tx out)
// Both outputs are registered. The registers hold the bit currently on the
// line, so the next bit is computed from the next-state position.
module eth_frame_gen #(
  parameter logic [47:0] DST_MAC      = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC      = 48'h0012_3456_789A,
  parameter logic [15:0] ETH_TYPE     = 16'h0800,
  parameter int unsigned PAYLOAD_LEN  = 46,
  parameter logic [7:0]  PAYLOAD_SEED = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  eth_frame_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG
  } state_e;

  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETH_TYPE};

  state_e      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [10:0] byte_q, byte_d;
  logic        data_q, data_d;
  logic        tx_q, tx_d;
  logic [10:0] last_byte;
  logic [7:0]  cur_byte;
  logic [6:0]  hdr_sel;
  logic        start;

  assign start = bus.transmit && bus.enable;

`ifdef ETH_FRAME_FCS_EN
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  logic [31:0] crc_q, crc_d;

  // Reflected CRC-32 over the bit currently on the line. While in FCS the
  // register holds, so crc_d is the final value for every FCS bit.
  always_comb begin
    crc_d = crc_q;
    if (state_q == SFD)
      crc_d = '1;
    else if (state_q == HEADER || state_q == PAYLOAD)
      crc_d = {1'b0, crc_q[31:1]} ^ ((crc_q[0] ^ data_q) ? CRC_POLY : 32'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '1;
    else        crc_q <= crc_d;
  end
`endif

  // Next position: bit/byte counters wrap into the next state at the
  // last bit of each field.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q + 3'd1;
    byte_d    = (bit_q == 3'd7) ? byte_q + 11'd1 : byte_q;
    last_byte = '0;
    case (state_q)
      PREAMBLE: last_byte = 11'd6;
      SFD:      last_byte = 11'd0;
      HEADER:   last_byte = 11'd13;
      PAYLOAD:  last_byte = 11'(PAYLOAD_LEN - 1);
      FCS:      last_byte = 11'd3;
      IFG:      last_byte = 11'd11;
      default:  last_byte = '0;
    endcase
    if (state_q == IDLE) begin
      bit_d  = '0;
      byte_d = '0;
      if (start) state_d = PREAMBLE;
    end else if (bit_q == 3'd7 && byte_q == last_byte) begin
      bit_d  = '0;
      byte_d = '0;
      case (state_q)
        PREAMBLE: state_d = SFD;
        SFD:      state_d = HEADER;
        HEADER:   state_d = PAYLOAD;
`ifdef ETH_FRAME_FCS_EN
        PAYLOAD:  state_d = FCS;
`else
        PAYLOAD:  state_d = IFG;
`endif
        FCS:      state_d = IFG;
        // A request still held at the end of IFG starts the next frame
        // back to back, giving exactly 96 idle bit times between frames.
        IFG:      state_d = start ? PREAMBLE : IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Bit to put on the line for the next position.
  always_comb begin
    hdr_sel  = 7'd111 - {byte_d[3:0], 3'b000};
    cur_byte = '0;
    case (state_d)
      PREAMBLE: cur_byte = 8'h55;
      SFD:      cur_byte = 8'hD5;
      HEADER:   cur_byte = HDR[hdr_sel -: 8];
      PAYLOAD:  cur_byte = PAYLOAD_SEED + byte_d[7:0];
      default:  cur_byte = '0;
    endcase
    data_d = cur_byte[bit_d];
`ifdef ETH_FRAME_FCS_EN
    if (state_d == FCS) data_d = ~crc_d[{byte_d[1:0], bit_d}];
`endif
    tx_d = (state_d != IDLE) && (state_d != IFG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      byte_q  <= '0;
      data_q  <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.eth_data_s = data_q;
  assign bus.Tx         = tx_q;

endmodule

// File: tb/tb_eth_frame_gen.sv
// tb_eth_frame_gen: directed bench for eth_frame_gen with default parameters.
// Frames are captured bit by bit while Tx is high and compared byte-wise
// against hand-written expected header/payload values.
module tb_eth_frame_gen;
  logic clk = 1'b0;
  logic rst_n;
  eth_frame_gen_if bus();

  eth_frame_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

`ifdef ETH_FRAME_FCS_EN
  localparam int FRAME_LEN = 576;
`else
  localparam int FRAME_LEN = 544;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic frame_bits [0:2047];
  int flen;

  // preamble x7, SFD, DST x6, SRC, EtherType
  logic [175:0] exp_hdr = 176'h55555555555555D5_FFFFFFFFFFFF_00123456789A_0800;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] fbyte(input int n);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = frame_bits[n*8 + b];
    return v;
  endfunction

  // Waits (bounded) for Tx high, then records bits until Tx drops.
  task automatic capture(output int len);
    int w;
    len = 0;
    w = 0;
    while (!bus.Tx && w < 2000) begin tick(); w++; end
    if (!bus.Tx) chk("tx_start_timeout", 32'd0, 32'd1);
    while (bus.Tx && len < 2048) begin
      frame_bits[len] = bus.eth_data_s;
      len++;
      tick();
    end
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] e;
    logic [31:0] crc;
    chk({tag, "_len"}, flen, FRAME_LEN);
    for (int i = 0; i < 22; i++) begin
      e = exp_hdr[175 - 8*i -: 8];
      if (fbyte(i) !== e) chk($sformatf("%s_hdr%0d", tag, i), fbyte(i), e);
    end
    chk({tag, "_hdr_all"}, 32'd1, 32'd1 & {31'd0, fbyte(21) === 8'h00});
    chk({tag, "_pay0"},  fbyte(22), 8'h00);
    chk({tag, "_pay10"}, fbyte(32), 8'h0A);
    chk({tag, "_pay45"}, fbyte(67), 8'h2D);
`ifdef ETH_FRAME_FCS_EN
    crc = 32'hFFFF_FFFF;
    for (int i = 64; i < flen; i++)
      crc = {1'b0, crc[31:1]} ^ ((crc[0] ^ frame_bits[i]) ? 32'hEDB88320 : 32'h0);
    chk({tag, "_residue"}, crc, 32'hDEBB20E3);
`else
    chk({tag, "_last"}, fbyte(flen/8 - 1), 8'h2D);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, gap, l2;
    bus.transmit = 1'b0;
    bus.enable   = 1'b1;
    rst_n        = 1'b0;
    repeat (3) tick();
    chk("rst_tx",   bus.Tx,         1'b0);
    chk("rst_data", bus.eth_data_s, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // single-cycle request: first bit visible right after the sampling edge
    bus.transmit = 1'b1;
    tick();
    bus.transmit = 1'b0;
    chk("lat_tx",   bus.Tx,         1'b1);
    chk("lat_data", bus.eth_data_s, 1'b1);
    capture(flen);
    check_frame("f1");
    repeat (150) tick();

    // enable low: request ignored
    bus.enable = 1'b0;
    bus.transmit = 1'b1;
    tick();
    bus.transmit = 1'b0;
    hi = 0;
    for (int i = 0; i < 1000; i++) begin if (bus.Tx) hi++; tick(); end
    chk("dis_hi", hi, 0);
    bus.enable = 1'b1;

    // held request: back-to-back frames, 96-cycle gap
    bus.transmit = 1'b1;
    capture(flen);
    chk("held_len1", flen, FRAME_LEN);
    gap = 0;
    while (!bus.Tx && gap < 300) begin gap++; tick(); end
    chk("held_gap", gap, 96);
    bus.transmit = 1'b0;
    capture(l2);
    chk("held_len2", l2, FRAME_LEN);
    repeat (150) tick();

    // second pulse mid-frame is ignored
    bus.transmit = 1'b1;
    tick();
    bus.transmit = 1'b0;
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.Tx) hi++;
      bus.transmit = (i == 100);
      tick();
    end
    bus.transmit = 1'b0;
    chk("midpulse_hi", hi, FRAME_LEN);

    // asynchronous reset mid-frame
    bus.transmit = 1'b1;
    tick();
    bus.transmit = 1'b0;
    repeat (200) tick();
    chk("pre_rst_tx", bus.Tx, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx",   bus.Tx,         1'b0);
    chk("async_data", bus.eth_data_s, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 50; i++) begin if (bus.Tx) hi++; tick(); end
    chk("dropped_hi", hi, 0);
    bus.transmit = 1'b1;
    tick();
    bus.transmit = 1'b0;
    capture(flen);
    check_frame("f2");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_frame_gen.md
# eth_frame_gen

Serial Ethernet frame generator for the 10BASE-T transmit path. On a `transmit` request it emits one complete frame (preamble, SFD, header, payload, optional FCS) as an NRZ bit stream at one bit per clock, with a frame-active strobe. It runs on the 10 MHz bit clock; Manchester encoding and NLP/idle signalling are handled by the surrounding transmitter.

## Interface
Parameters:
- `DST_MAC`, 48'hFFFF_FFFF_FFFF, destination address, sent first byte = bits [47:40].
- `SRC_MAC`, 48'h0012_3456_789A, source address, same byte order.
- `ETH_TYPE`, 16'h0800, EtherType/length field, high byte first.
- `PAYLOAD_LEN`, 46, payload byte count, legal range 46..1500.
- `PAYLOAD_SEED`, 8'h00, payload byte n = (PAYLOAD_SEED + n) mod 256.

Ports:
- `clk` in 1: 10 MHz bit clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `transmit` in 1: start request, level-sampled.
- `enable` in 1: block enable; requests ignored while low.
- `eth_data_s` out 1: serial NRZ frame bit.
- `Tx` out 1: high exactly while a frame bit is on `eth_data_s`.

## Operation
- States: IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG.
- IDLE: `Tx`=0, `eth_data_s`=0. If `transmit`=1 and `enable`=1 on a rising edge, go to PREAMBLE.
- PREAMBLE: 7 bytes 0x55 (56 bits, alternating 1,0 starting with 1).
- SFD: byte 0xD5.
- HEADER: DST_MAC (6 bytes), SRC_MAC (6 bytes), ETH_TYPE (2 bytes), 112 bits.
- PAYLOAD: PAYLOAD_LEN bytes of the seed pattern.
- FCS: 4 bytes of CRC-32 (see Configuration). Then IFG.
- IFG: 96 bit times, `Tx`=0 and `eth_data_s`=0, `transmit` ignored. Then IDLE.
- Every byte is sent LSB first.
- `transmit` asserted during a frame or IFG is ignored, not queued. Held high, it starts a new frame immediately after IFG.
- `enable` going low mid-frame does not abort; the frame and IFG complete.
- Counters: a 3-bit bit index plus an 11-bit byte index, reset at each state entry.

## Timing
- Reset: state IDLE, `Tx`=0, `eth_data_s`=0, CRC register = 0xFFFFFFFF, all counters 0. Reset takes effect immediately, including mid-frame, and the frame is dropped.
- Latency: `transmit` sampled at edge k gives `Tx`=1 and the first preamble bit (1) registered at edge k, visible in cycle k+1.
- `Tx` high for (8+14+PAYLOAD_LEN+4)×8 consecutive cycles, i.e. 576 for PAYLOAD_LEN=46. Without FCS, subtract 32.
- Minimum request-to-request spacing: frame length + 96 cycles.
- Both outputs are registered; there is no combinational path from any input.

## Configuration
- `ETH_FRAME_FCS_EN` defined: a CRC-32 is computed over the header and payload bits as they are sent.
  - Reflected form: polynomial 0xEDB88320, shift right, initialised to 0xFFFFFFFF at SFD.
  - FCS state sends the complemented register, bit 0 first, 32 bits.
- `ETH_FRAME_FCS_EN` undefined: no CRC logic. PAYLOAD goes directly to IFG, and the frame is 32 bits shorter.

## Test plan
- Reset then a 1-cycle `transmit` with `enable`=1: `Tx` is high for 576 cycles. The first 64 bits are 55 55 55 55 55 55 55 D5 LSB-first, then 0x FF ×6 for the destination.
- Capture the full frame with FCS enabled: running the reflected CRC-32 over header+payload+FCS gives the residue 0xDEBB20E3.
- `enable`=0 with `transmit` pulsed: `Tx` stays 0 for 1000 cycles.
- `transmit` held high: frames are separated by exactly 96 low cycles of `Tx`, and a second pulse mid-frame has no effect.
- `rst_n` low at cycle 200 of a frame: `Tx` and `eth_data_s` drop to 0 asynchronously. The next request produces a full, correct frame.
- Build without `ETH_FRAME_FCS_EN`: `Tx` is high 544 cycles. The last 8 bits are payload byte 45 = 0x2D with PAYLOAD_SEED=0.
